// File: rtl/mmio_console_uart.sv
// Memory-mapped console: stores to CONSOLE_ADDR go through a byte FIFO to an 8N1 UART TX line.
// Halt is held off until the console drains. Define CONSOLE_PARITY_EN for an even-parity bit (8E1).
module mmio_console_uart #(
    parameter logic [31:0] CONSOLE_ADDR = 32'h0000_FFFC,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_FFF8,
    parameter logic [31:0] STATUS_ADDR  = 32'h0000_FFF4,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx,
    output logic        halt,
    output logic        overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty, full, push, pop, accept, halt_req;
    state_t            state, state_next;
    logic [BAUD_W-1:0] baud, baud_next;
    logic              baud_done;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        shreg, shreg_next;
    logic              tx_next;
    logic              unused_wdata;
`ifdef CONSOLE_PARITY_EN
    logic              parity_bit;
`endif

    assign unused_wdata = ^writedata[31:8];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign push      = memwrite && (dataadr == CONSOLE_ADDR);
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign accept    = push && (!full || pop);
    assign baud_done = (baud == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= writedata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            halt_req <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(accept) - CNT_W'(pop);
            if (push && !accept)
                overflow <= 1'b1;
            if (memwrite && (dataadr == HALT_ADDR))
                halt_req <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        pop          = 1'b0;
        tx_next      = 1'b1;
        if (state != IDLE)
            baud_next = baud_done ? '0 : baud + 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    shreg_next   = mem[rd_ptr];
                    bit_idx_next = '0;
                    baud_next    = '0;
                    state_next   = START;
                end
            end
            START:
                if (baud_done)
                    state_next = DATA;
            DATA: begin
                if (baud_done) begin
                    if (bit_idx == 3'd7) begin
`ifdef CONSOLE_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        shreg_next   = shreg >> 1;
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            PARITY:
                if (baud_done)
                    state_next = STOP;
            STOP:
                if (baud_done)
                    state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
        // tx is registered from the upcoming state so the line never glitches.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
`ifdef CONSOLE_PARITY_EN
            PARITY:  tx_next = parity_bit;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            halt    <= 1'b0;
`ifdef CONSOLE_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
            tx      <= tx_next;
            halt    <= halt_req && empty && (state == IDLE);
`ifdef CONSOLE_PARITY_EN
            if (pop)
                parity_bit <= ^mem[rd_ptr];
`endif
        end
    end

    always_comb begin
        readdata = '0;
        if (dataadr == STATUS_ADDR) begin
`ifdef CONSOLE_PARITY_EN
            readdata = {26'b0, 1'b1, halt_req, overflow, halt, full, empty};
`else
            readdata = {27'b0, halt_req, overflow, halt, full, empty};
`endif
        end
    end

endmodule

// File: doc/mmio_console_uart.md
Name: mmio_console_uart

Overview:
- Memory-mapped console peripheral on the core's data-memory store port, directly downstream of the core.
- Captures stores to the console address into a byte FIFO and serialises them on a UART TX line (8N1, LSB first).
- Exposes a status word at a read address.
- Latches halt requests and asserts halt only after all queued console bytes have fully left the TX line, so final prints are never truncated.

Parameters:
- CONSOLE_ADDR, 32'h0000_FFFC, store target for console bytes (writedata[7:0]).
- HALT_ADDR, 32'h0000_FFF8, any store here requests halt.
- STATUS_ADDR, 32'h0000_FFF4, read-only status word.
- FIFO_DEPTH, 8, console byte FIFO entries; power of two, >= 2.
- CLKS_PER_BIT, 16, clk cycles per UART bit; >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- memwrite  in  1  store strobe from core, sampled on rising edge.
- dataadr  in  32  store/load address from core.
- writedata  in  32  store data from core.
- readdata  out  32  status word when dataadr==STATUS_ADDR, else 0; combinational.
- tx  out  1  UART serial output; idle high.
- halt  out  1  registered; high when halt requested and console fully drained.
- overflow  out  1  sticky; set when a console byte was dropped.

Behaviour:
- Reset (edge with reset=1): FIFO emptied, FSM=IDLE, tx=1, halt=0, overflow=0, halt_req=0, bit and baud counters=0. A reset mid-frame aborts the frame; tx is 1 from the following cycle.
- Push: memwrite && dataadr==CONSOLE_ADDR at edge N → writedata[7:0] enqueued at N.
  - Accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs at the same edge (count unchanged).
  - Otherwise the byte is dropped and overflow is set at N, sticky until reset.
- Stores to any other address are ignored. The block never stalls the core.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits. empty = count==0, full = count==FIFO_DEPTH.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: tx=1. If !empty at an edge, pop the head into an 8-bit shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shreg[0] for each of 8 bits, shifting right after each CLKS_PER_BIT period. A 3-bit index counts 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - A byte pushed at edge N into an empty FIFO with FSM idle is popped at edge N+1. tx falls after edge N+1.
  - One frame is 10*CLKS_PER_BIT cycles. Back-to-back frames have exactly 1 idle cycle between STOP and the next START.
- tx is driven from a register (glitch-free).
- Halt: memwrite && dataadr==HALT_ADDR sets halt_req (sticky). halt registers (halt_req && empty && FSM==IDLE).
  - With an empty FIFO and idle FSM, halt rises at edge N+1 after a halt store at edge N.
  - Pushes after halt_req remain accepted and delay halt.
- Status word: readdata = {27'b0, halt_req, overflow, halt, full, empty}, bits [4:0].
- A simultaneous console push and halt store in the same cycle is impossible (single address); no special case.

Optional Feature:
- Macro: CONSOLE_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length is 11*CLKS_PER_BIT.
  - Status bit 5 reads 1 (parity-capable).
- Undefined: no PARITY state, 10-bit frames, status bit 5 reads 0.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Reset release, no stores → tx=1, halt=0, overflow=0; status read at STATUS_ADDR returns 32'h0000_0001.
- Store 0x41 to CONSOLE_ADDR at edge N → tx low cycles N+1..N+4, then data bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop high. Returns to idle at N+41. empty=1 after edge N+1.
- Stores 0x30..0x35 on 6 consecutive cycles with FIFO initially empty:
  - 0x30 is popped at the second edge, so 0x30..0x34 are accepted and 0x35 is dropped.
  - overflow=1; serial output decodes to 0x30,0x31,0x32,0x33,0x34; one idle cycle between frames.
- Store 0x48 to console then a store to HALT_ADDR the next cycle:
  - halt stays 0 during the frame; halt_req status bit=1.
  - halt rises exactly 1 cycle after the FSM returns to IDLE with the FIFO empty.
- Assert reset during DATA bit 3 of byte 0xA5 with 2 bytes queued → tx=1 the next cycle; FIFO empty; no further frames; overflow and halt cleared.
- With CONSOLE_PARITY_EN defined: store 0x07 → parity bit 1 after bit 7, frame 44 cycles. Store 0x03 → parity bit 0.
